// File: rtl/logic_basic_gray_pointer.sv
`default_nettype none
// ============================================================================
// Module      : logic_basic_gray_pointer
// Description : Pointer unit for one side of a dual-clock FIFO.
//               Holds a local (WIDTH+1)-bit binary pointer, publishes it as a
//               registered gray code, synchronizes the remote gray pointer,
//               converts it back to binary and derives full/empty, level and
//               the increment handshake from flops only.
//
// Parameters  : WIDTH    address bits; pointers are WIDTH+1 bits (WIDTH >= 1)
//               STAGES   synchronizer flops on remote_gray (STAGES >= 2)
//               IS_WRITE 1: write side (blocks on full), 0: read side
//                        (blocks on empty)
//
// Ports       : aclk         clock of this pointer's domain
//               areset_n     asynchronous reset, active-low
//               inc_valid    request to advance the pointer by one
//               inc_ready    pointer may advance (write: !full, read: !empty)
//               addr         local binary pointer without wrap bit (RAM addr)
//               gray         registered gray code of the local pointer
//               remote_gray  gray pointer from the remote clock domain
//               full         write side: FIFO full; read side: constant 0
//               empty        read side: FIFO empty; write side: constant 0
//               level        FIFO occupancy as seen by this side
//
// Options     : LOGIC_GRAY_POINTER_LEVEL_EN
//               defined   -> level is registered bin/rbin difference
//                            (lags the flags by one cycle)
//               undefined -> level tied to 0, no subtractor
//
// Revision    : 1.0  initial release
// ============================================================================
module logic_basic_gray_pointer #(
  parameter int WIDTH    = 4,
  parameter int STAGES   = 2,
  parameter bit IS_WRITE = 1'b1
) (
  input  logic             aclk,
  input  logic             areset_n,
  input  logic             inc_valid,
  output logic             inc_ready,
  output logic [WIDTH-1:0] addr,
  output logic [WIDTH:0]   gray,
  input  logic [WIDTH:0]   remote_gray,
  output logic             full,
  output logic             empty,
  output logic [WIDTH:0]   level
);

  localparam logic [WIDTH:0] PTR_ONE = {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH:0]              bin_q;
  logic [WIDTH:0]              bin_next;
  logic [WIDTH:0]              gray_q;
  logic [WIDTH:0]              rbin_q;
  logic [STAGES-1:0][WIDTH:0]  sync_q;
  logic                        full_cond;
  logic                        empty_cond;
  logic                        accept;

  // Gray to binary: each binary bit is the XOR of all gray bits at and above it.
  function automatic logic [WIDTH:0] gray_to_bin(input logic [WIDTH:0] g);
    logic [WIDTH:0] b;
    b[WIDTH] = g[WIDTH];
    for (int i = WIDTH - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Full: same address, opposite wrap bit. Empty: identical pointers.
  // Both decode registered state only, so there is no input-to-output path.
  always_comb begin
    full_cond  = (bin_q[WIDTH] != rbin_q[WIDTH]) &&
                 (bin_q[WIDTH-1:0] == rbin_q[WIDTH-1:0]);
    empty_cond = (bin_q == rbin_q);
  end

  assign inc_ready = IS_WRITE ? !full_cond : !empty_cond;
  assign accept    = inc_valid & inc_ready;
  assign bin_next  = bin_q + PTR_ONE;

  // Binary and gray copies advance on the same edge; the gray value leaving
  // this domain is always a flop output, never a decoded glitchy signal.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      bin_q  <= '0;
      gray_q <= '0;
    end else if (accept) begin
      bin_q  <= bin_next;
      gray_q <= bin_next ^ (bin_next >> 1);
    end
  end

  // Remote pointer: STAGES synchronizer flops, then a registered gray-to-binary
  // conversion. A remote change reaches the flags STAGES+1 cycles later.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      sync_q <= '0;
      rbin_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], remote_gray};
      rbin_q <= gray_to_bin(sync_q[STAGES-1]);
    end
  end

`ifdef LOGIC_GRAY_POINTER_LEVEL_EN
  logic [WIDTH:0] level_q;

  // Modular difference; the extra wrap bit makes 2**WIDTH representable.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      level_q <= '0;
    end else begin
      level_q <= IS_WRITE ? (bin_q - rbin_q) : (rbin_q - bin_q);
    end
  end

  assign level = level_q;
`else
  assign level = '0;
`endif

  assign addr  = bin_q[WIDTH-1:0];
  assign gray  = gray_q;
  assign full  = IS_WRITE ? full_cond : 1'b0;
  assign empty = IS_WRITE ? 1'b0 : empty_cond;

endmodule
`default_nettype wire

// File: tb/tb_logic_basic_gray_pointer.sv
`default_nettype none
// ============================================================================
// Module      : tb_logic_basic_gray_pointer
// Description : Bench for logic_basic_gray_pointer. A write-side and a
//               read-side instance (WIDTH=2, STAGES=2) share one clock. Their
//               remote inputs are either driven directly by the bench or
//               cross-connected to form a FIFO pointer pair. Expected values
//               come from an occupancy model based on pointer counts and a
//               delayed view of the remote count.
// Revision    : 1.0  initial release
// ============================================================================
module tb_logic_basic_gray_pointer;

  localparam int W     = 2;
  localparam int S     = 2;
  localparam int DEPTH = 1 << W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          areset_n;
  logic          wv, rv;
  logic          link;
  logic [W:0]    remw_drv, remr_drv;

  logic          w_ready, w_full, w_empty;
  logic [W-1:0]  w_addr;
  logic [W:0]    w_gray, w_level, w_remote;
  logic          r_ready, r_full, r_empty;
  logic [W-1:0]  r_addr;
  logic [W:0]    r_gray, r_level, r_remote;

  int checks   = 0;
  int failures = 0;

  function automatic logic [W:0] to_gray(input logic [W:0] n);
    return n ^ (n >> 1);
  endfunction

  assign w_remote = link ? r_gray : to_gray(remw_drv);
  assign r_remote = link ? w_gray : to_gray(remr_drv);

  logic_basic_gray_pointer #(.WIDTH(W), .STAGES(S), .IS_WRITE(1'b1)) u_wr (
    .aclk(clk), .areset_n(areset_n), .inc_valid(wv), .inc_ready(w_ready),
    .addr(w_addr), .gray(w_gray), .remote_gray(w_remote),
    .full(w_full), .empty(w_empty), .level(w_level)
  );

  logic_basic_gray_pointer #(.WIDTH(W), .STAGES(S), .IS_WRITE(1'b0)) u_rd (
    .aclk(clk), .areset_n(areset_n), .inc_valid(rv), .inc_ready(r_ready),
    .addr(r_addr), .gray(r_gray), .remote_gray(r_remote),
    .full(r_full), .empty(r_empty), .level(r_level)
  );

  // Model: counts of accepted writes/reads (mod 2*DEPTH), plus queues holding
  // the remote count as sampled on recent edges; element 0 is the one each
  // side currently "sees" after the synchronizer latency.
  logic [W:0] m_wc, m_rc, m_lw, m_lr;
  logic [W:0] qw[$];
  logic [W:0] qr[$];

  function automatic logic [W:0] occ_w();
    return m_wc - qw[0];
  endfunction

  function automatic logic [W:0] occ_r();
    return qr[0] - m_rc;
  endfunction

  task automatic model_reset();
    m_wc = '0; m_rc = '0; m_lw = '0; m_lr = '0;
    qw.delete(); qr.delete();
    for (int i = 0; i < S + 1; i++) begin
      qw.push_back('0);
      qr.push_back('0);
    end
  endtask

  // Advance the model across one clock edge using the current inputs.
  task automatic model_edge();
    logic [W:0] inw, inr;
    logic       rw, rr;
    inw  = link ? m_rc : remw_drv;
    inr  = link ? m_wc : remr_drv;
    rw   = (occ_w() != DEPTH[W:0]);
    rr   = (occ_r() != '0);
    m_lw = occ_w();
    m_lr = occ_r();
    if (wv && rw) m_wc = m_wc + 1'b1;
    if (rv && rr) m_rc = m_rc + 1'b1;
    qw.push_back(inw); void'(qw.pop_front());
    qr.push_back(inr); void'(qr.pop_front());
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ph);
    logic       fexp, eexp;
    logic [W:0] lw, lr;
    fexp = (occ_w() == DEPTH[W:0]);
    eexp = (occ_r() == '0);
`ifdef LOGIC_GRAY_POINTER_LEVEL_EN
    lw = m_lw; lr = m_lr;
`else
    lw = '0; lr = '0;
`endif
    chk({ph, ".w_addr"},  32'(w_addr),  32'(m_wc[W-1:0]));
    chk({ph, ".w_gray"},  32'(w_gray),  32'(to_gray(m_wc)));
    chk({ph, ".w_full"},  32'(w_full),  32'(fexp));
    chk({ph, ".w_empty"}, 32'(w_empty), 32'(1'b0));
    chk({ph, ".w_ready"}, 32'(w_ready), 32'(!fexp));
    chk({ph, ".w_level"}, 32'(w_level), 32'(lw));
    chk({ph, ".r_addr"},  32'(r_addr),  32'(m_rc[W-1:0]));
    chk({ph, ".r_gray"},  32'(r_gray),  32'(to_gray(m_rc)));
    chk({ph, ".r_full"},  32'(r_full),  32'(1'b0));
    chk({ph, ".r_empty"}, 32'(r_empty), 32'(eexp));
    chk({ph, ".r_ready"}, 32'(r_ready), 32'(!eexp));
    chk({ph, ".r_level"}, 32'(r_level), 32'(lr));
  endtask

  task automatic tick(input string ph);
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_all(ph);
  endtask

  // Called at a negedge: reset is checked before any clock edge occurs.
  task automatic async_reset(input string ph);
    areset_n = 1'b0;
    remw_drv = '0;
    remr_drv = '0;
    #1;
    model_reset();
    check_all(ph);
    chk({ph, ".w_gray0"},  32'(w_gray),  32'(0));
    chk({ph, ".r_empty1"}, 32'(r_empty), 32'(1));
    #2;
    areset_n = 1'b1;
    wv = 1'b0;
    rv = 1'b0;
  endtask

  logic [W:0] gseq [4];
  logic       eseq [3];
  logic [W:0] prev_wg;
  int         wr_total;

  initial begin
    gseq[0] = 3'b001; gseq[1] = 3'b011; gseq[2] = 3'b010; gseq[3] = 3'b110;
    eseq[0] = 1'b1;   eseq[1] = 1'b1;   eseq[2] = 1'b0;
    link = 1'b0; wv = 1'b0; rv = 1'b0;
    remw_drv = '0; remr_drv = '0;
    areset_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    areset_n = 1'b1;

    // Reset state of both sides.
    check_all("t1");
    chk("t1.w_ready1", 32'(w_ready), 32'(1));
    chk("t1.r_ready0", 32'(r_ready), 32'(0));

    // Write side fills with the remote pointer frozen at 0.
    wv = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick("t2");
      chk("t2.gray_seq", 32'(w_gray), 32'(gseq[i]));
    end
    chk("t2.full_after4", 32'(w_full), 32'(1));
    tick("t2.blocked");
    chk("t2.addr_stays", 32'(w_addr), 32'(0));
    wv = 1'b0;
    repeat (2) tick("t5.level");

    // Read side sees one remote entry after the synchronizer latency.
    remr_drv = 3'd1;
    for (int i = 0; i < 3; i++) begin
      tick("t3");
      chk("t3.empty_lat", 32'(r_empty), 32'(eseq[i]));
    end
    rv = 1'b1;
    tick("t3.read");
    chk("t3.empty_again", 32'(r_empty), 32'(1));
    rv = 1'b0;
    tick("t3.idle");

    // Reset in the middle of a write burst.
    wv = 1'b1;
    repeat (2) tick("t6.burst");
    async_reset("t6");
    tick("t6.post");

    // Connected pair with random traffic; pointers wrap many times.
    link = 1'b1;
    wr_total = 0;
    for (int c = 0; c < 300; c++) begin
      wv = ($urandom_range(0, 9) < 7);
      rv = ($urandom_range(0, 1) == 1);
      prev_wg = to_gray(m_wc);
      tick("t4");
      if (to_gray(m_wc) != prev_wg) begin
        wr_total++;
        chk("t4.gray_1bit", 32'($countones(w_gray ^ prev_wg)), 32'(1));
      end
    end
    chk("t4.enough_writes", 32'(wr_total >= 20), 32'(1));
    wv = 1'b1;
    rv = 1'b1;
    tick("t6b.burst");
    async_reset("t6b");
    link = 1'b0;
    tick("t6b.post");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
